// File: rtl/delay_scheduler.sv
// rtl/delay_scheduler.sv - round-robin shared microsecond delay engine
module delay_scheduler #(
  parameter int N_CH     = 4,
  parameter int CLK_FREQ = 36,
  parameter int DLY_W    = 16
) (
  input  logic                      i_clk_36MHz,
  input  logic                      i_reset,
  input  logic [N_CH-1:0]           i_req,
  input  logic [N_CH*DLY_W-1:0]     i_delay_us,
  input  logic [N_CH-1:0]           i_cancel,
  output logic [N_CH-1:0]           o_ack,
  output logic [N_CH-1:0]           o_done,
  output logic                      o_busy,
  output logic [$clog2(N_CH)-1:0]   o_active_ch
);

  localparam int CH_W = $clog2(N_CH);
  localparam int PS_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(CLK_FREQ - 1);
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(N_CH - 1);
  localparam logic [N_CH-1:0]  CH_ONE  = {{(N_CH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DONE
  } state_t;

  state_t            state;
  logic [PS_W-1:0]   prescaler;
  logic [DLY_W-1:0]  remaining;
  logic [CH_W-1:0]   rr_ptr;

  logic              grant_valid;
  logic [CH_W-1:0]   grant_idx;
  logic [DLY_W-1:0]  grant_dly;
  logic [CH_W-1:0]   next_ptr;
  logic              cancel_hit;
  int                scan_ch;

  // Round-robin search: first asserted request at or after rr_ptr, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_ch     = 0;
    for (int i = 0; i < N_CH; i++) begin
      scan_ch = int'(rr_ptr) + i;
      if (scan_ch >= N_CH) begin
        scan_ch = scan_ch - N_CH;
      end
      if (!grant_valid && i_req[scan_ch]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_W'(scan_ch);
      end
    end
  end

  // Delay of the would-be grantee, next pointer and owner-only cancel.
  always_comb begin
    grant_dly  = i_delay_us[int'(grant_idx)*DLY_W +: DLY_W];
    next_ptr   = (grant_idx == CH_LAST) ? '0 : grant_idx + 1'b1;
    cancel_hit = i_cancel[o_active_ch];
  end

  // Scheduler FSM: grant, count microseconds, pulse completion.
  always_ff @(posedge i_clk_36MHz or negedge i_reset) begin
    if (!i_reset) begin
      state       <= ST_IDLE;
      prescaler   <= '0;
      remaining   <= '0;
      rr_ptr      <= '0;
      o_ack       <= '0;
      o_done      <= '0;
      o_busy      <= 1'b0;
      o_active_ch <= '0;
    end else begin
      o_ack  <= '0;
      o_done <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            o_active_ch <= grant_idx;
            remaining   <= grant_dly;
            prescaler   <= '0;
            rr_ptr      <= next_ptr;
            o_ack       <= CH_ONE << grant_idx;
            o_busy      <= 1'b1;
            if (grant_dly == '0) begin
              // Zero delay completes in the same cycle the ack is shown.
              state  <= ST_DONE;
              o_done <= CH_ONE << grant_idx;
            end else begin
              state <= ST_COUNT;
            end
          end else begin
            o_busy <= 1'b0;
          end
        end
        ST_COUNT: begin
          if (cancel_hit) begin
            // Cancel has priority over a coincident expiry.
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else if (prescaler == PS_LAST) begin
            prescaler <= '0;
            if (remaining == DLY_W'(1)) begin
              state  <= ST_DONE;
              o_done <= CH_ONE << o_active_ch;
            end else begin
              remaining <= remaining - 1'b1;
            end
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_scheduler.sv
// tb/tb_delay_scheduler.sv - bench for delay_scheduler
module tb_delay_scheduler;

  localparam int N     = 4;
  localparam int CLKF  = 36;
  localparam int DW    = 16;
  localparam int CW    = $clog2(N);

  logic              clk;
  logic              i_reset;
  logic [N-1:0]      i_req;
  logic [N*DW-1:0]   i_delay_us;
  logic [N-1:0]      i_cancel;
  logic [N-1:0]      o_ack;
  logic [N-1:0]      o_done;
  logic              o_busy;
  logic [CW-1:0]     o_active_ch;

  delay_scheduler #(.N_CH(N), .CLK_FREQ(CLKF), .DLY_W(DW)) dut (
    .i_clk_36MHz (clk),
    .i_reset     (i_reset),
    .i_req       (i_req),
    .i_delay_us  (i_delay_us),
    .i_cancel    (i_cancel),
    .o_ack       (o_ack),
    .o_done      (o_done),
    .o_busy      (o_busy),
    .o_active_ch (o_active_ch)
  );

  initial clk = 1'b0;
  always #14 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  bit cmp_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: an abstract owner/time-left view of the scheduler.
  int           m_mode;   // 0 idle, 1 counting, 2 done
  int           m_left;   // clock edges remaining until completion
  int           m_owner;
  int           m_rr;
  int           m_g;
  int           m_d;
  logic [N-1:0] e_ack, e_done;

  always @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      m_mode = 0; m_left = 0; m_owner = 0; m_rr = 0;
      e_ack = '0; e_done = '0;
    end else begin
      e_ack = '0; e_done = '0;
      case (m_mode)
        0: begin
          m_g = -1;
          for (int i = 0; i < N; i++)
            if (m_g < 0 && i_req[(m_rr + i) % N]) m_g = (m_rr + i) % N;
          if (m_g >= 0) begin
            m_owner = m_g;
            m_rr = (m_g + 1) % N;
            e_ack[m_g] = 1'b1;
            m_d = int'(i_delay_us[m_g*DW +: DW]);
            if (m_d == 0) begin
              m_mode = 2;
              e_done[m_g] = 1'b1;
            end else begin
              m_mode = 1;
              m_left = CLKF * m_d;
            end
          end
        end
        1: begin
          if (i_cancel[m_owner]) m_mode = 0;
          else begin
            m_left--;
            if (m_left == 0) begin
              m_mode = 2;
              e_done[m_owner] = 1'b1;
            end
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en && i_reset) begin
      check("ack", o_ack, e_ack);
      check("done", o_done, e_done);
      check("busy", o_busy, m_mode != 0);
      check("active_ch", o_active_ch, m_owner);
    end
  end

  task automatic set_dly(input int ch, input int d);
    i_delay_us[ch*DW +: DW] = DW'(d);
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    i_req = '0;
    i_cancel = '0;
    repeat (3) @(negedge clk);
    i_reset = 1'b1;
  endtask

  // Wait for an ack (dropping that request, as requesters must) or a done.
  task automatic wait_sig(input bit is_done, input int limit, output int ch, output int at);
    ch = -1;
    at = 0;
    for (int i = 0; i < limit && ch < 0; i++) begin
      @(negedge clk);
      if (is_done ? (o_done != 0) : (o_ack != 0)) begin
        for (int k = 0; k < N; k++)
          if (is_done ? o_done[k] : o_ack[k]) ch = k;
        at = cyc;
        if (!is_done) i_req[ch] = 1'b0;
      end
    end
    if (ch < 0) begin
      n_total++;
      $display("FAIL %s_timeout: got none expected pulse within %0d cycles",
               is_done ? "done" : "ack", limit);
    end
  endtask

  int ch, ta, td, prev_done, done_cnt;

  initial begin
    i_reset = 1'b0;
    i_req = '0;
    i_cancel = '0;
    i_delay_us = '0;
    do_reset();
    cmp_en = 1'b1;
    check("reset_ack", o_ack, 0);
    check("reset_done", o_done, 0);
    check("reset_busy", o_busy, 0);
    check("reset_active_ch", o_active_ch, 0);

    // Single request, D=3 -> 108 cycles.
    set_dly(1, 3);
    i_req[1] = 1'b1;
    wait_sig(0, 10, ch, ta);
    check("single_ack_ch", ch, 1);
    check("single_active_ch", o_active_ch, 1);
    check("single_busy", o_busy, 1);
    wait_sig(1, 200, ch, td);
    check("single_done_ch", ch, 1);
    check("single_latency", td - ta, 108);
    repeat (2) @(negedge clk);

    // Zero delay: ack and done together, busy for one cycle.
    set_dly(2, 0);
    i_req[2] = 1'b1;
    wait_sig(0, 10, ch, ta);
    check("zero_ack_ch", ch, 2);
    check("zero_done_same", o_done, 4'b0100);
    check("zero_busy", o_busy, 1);
    @(negedge clk);
    check("zero_busy_after", o_busy, 0);

    // Fairness after reset: 0,1,2,3 then 0 before 2.
    do_reset();
    for (int k = 0; k < N; k++) set_dly(k, 1);
    i_req = '1;
    prev_done = 0;
    for (int g = 0; g < N; g++) begin
      wait_sig(0, 100, ch, ta);
      check("fair_order", ch, g);
      if (g > 0) check("fair_gap", ta - prev_done, 2);
      wait_sig(1, 100, ch, td);
      check("fair_latency", td - ta, 36);
      prev_done = td;
    end
    i_req[0] = 1'b1;
    i_req[2] = 1'b1;
    wait_sig(0, 100, ch, ta);
    check("fair_rerequest_first", ch, 0);
    check("fair_rerequest_gap", ta - prev_done, 2);
    wait_sig(1, 100, ch, td);
    wait_sig(0, 100, ch, ta);
    check("fair_rerequest_second", ch, 2);
    wait_sig(1, 100, ch, td);
    repeat (2) @(negedge clk);

    // Cancel of the counting owner at COUNT cycle 50.
    set_dly(0, 5);
    i_req[0] = 1'b1;
    wait_sig(0, 10, ch, ta);
    repeat (50) @(negedge clk);
    i_cancel[0] = 1'b1;
    @(negedge clk);
    i_cancel = '0;
    check("cancel_busy", o_busy, 0);
    done_cnt = 0;
    repeat (250) begin
      @(negedge clk);
      if (o_done != 0) done_cnt++;
    end
    check("cancel_no_done", done_cnt, 0);

    // Cancel of a different channel is ignored.
    set_dly(0, 2);
    i_req[0] = 1'b1;
    wait_sig(0, 10, ch, ta);
    repeat (10) @(negedge clk);
    i_cancel = 4'b1000;
    repeat (20) @(negedge clk);
    i_cancel = '0;
    wait_sig(1, 200, ch, td);
    check("other_cancel_ch", ch, 0);
    check("other_cancel_latency", td - ta, 72);
    repeat (2) @(negedge clk);

    // Cancel in the expiry cycle wins.
    set_dly(1, 1);
    i_req[1] = 1'b1;
    wait_sig(0, 10, ch, ta);
    repeat (35) @(negedge clk);
    i_cancel[1] = 1'b1;
    @(negedge clk);
    i_cancel = '0;
    check("expiry_cancel_done", o_done, 0);
    check("expiry_cancel_busy", o_busy, 0);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-count.
    set_dly(3, 4);
    i_req[3] = 1'b1;
    wait_sig(0, 10, ch, ta);
    repeat (20) @(negedge clk);
    #3 i_reset = 1'b0;
    #1;
    check("areset_ack", o_ack, 0);
    check("areset_done", o_done, 0);
    check("areset_busy", o_busy, 0);
    check("areset_active_ch", o_active_ch, 0);
    i_req = '0;
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
    set_dly(3, 2);
    i_req[3] = 1'b1;
    wait_sig(0, 10, ch, ta);
    check("post_reset_ch", ch, 3);
    wait_sig(1, 200, ch, td);
    check("post_reset_latency", td - ta, 72);

    // Randomized requesters and cancels against the model.
    repeat (15000) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (i_req[k]) begin
          if (o_ack[k]) i_req[k] = 1'b0;
        end else if ($urandom_range(7) == 0) begin
          set_dly(k, int'($urandom_range(3)));
          i_req[k] = 1'b1;
        end
      end
      i_cancel = '0;
      if ($urandom_range(15) == 0) i_cancel[$urandom_range(N-1)] = 1'b1;
    end
    i_req = '0;
    i_cancel = '0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
